// File: rtl/divider_if.sv
// Divider request/result bundle: operands and start request in, result and status out.
// Latency: none (wires only); the divider registers every output it drives.
// Backpressure: the requester watches busy; a load raised while busy is dropped by the divider.
//
// Ports (as seen from the divider / slave modport):
//   load        in   start request
//   dividend    in   8-bit unsigned numerator
//   divisor     in   4-bit unsigned denominator
//   quotient    out  8-bit unsigned quotient (registered)
//   remainder   out  4-bit unsigned remainder (registered)
//   busy        out  division in progress
//   op_ready    out  quotient/remainder hold a completed result
//   div_by_zero out  completed operation had divisor 0 (only with DIV_BY_ZERO_CHECK_EN)
interface divider_if;
    logic       load;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       op_ready;
    logic       div_by_zero;

    modport master (
        output load, dividend, divisor,
        input  quotient, remainder, busy, op_ready, div_by_zero
    );

    modport slave (
        input  load, dividend, divisor,
        output quotient, remainder, busy, op_ready, div_by_zero
    );
endinterface

// File: rtl/divider.sv
// Unsigned 8-bit / 4-bit restoring divider, one quotient bit per clock, MSB first.
// Latency: result 8 cycles after the accepted load edge (1 cycle for divisor 0 with DIV_BY_ZERO_CHECK_EN).
// Backpressure: load is accepted only in IDLE or DONE; a load while busy is ignored entirely.
//
// Ports:
//   clk  - single clock, all state on the rising edge
//   rst  - synchronous active-high reset, overrides load
//   bus  - divider_if.slave: load/dividend/divisor in; quotient/remainder/busy/op_ready/div_by_zero out
//
// Build option: define DIV_BY_ZERO_CHECK_EN to short-circuit divisor==0 to a 1-cycle
// result with div_by_zero flagged; otherwise divisor 0 runs the normal 8 steps and
// div_by_zero stays 0.
module divider (
    input  logic     clk,
    input  logic     rst,
    divider_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state, state_nxt;

    // dvd doubles as the quotient accumulator: each step shifts the next
    // dividend bit out of the top and the new quotient bit into the bottom.
    logic [7:0] dvd, dvd_nxt;
    logic [3:0] dvs, dvs_nxt;
    logic [4:0] partial, partial_nxt;
    logic [2:0] cnt, cnt_nxt;

    logic [7:0] quotient_q, quotient_nxt;
    logic [3:0] remainder_q, remainder_nxt;
    logic       busy_q, busy_nxt;
    logic       op_ready_q, op_ready_nxt;
    logic       dbz_q, dbz_nxt;

    // One restoring step.
    logic [4:0] partial_sh;
    logic       ge;
    logic [4:0] partial_step;
    logic [7:0] dvd_step;

    // After every step partial < divisor <= 15, so bit 4 is dropped on the
    // shift; with divisor 0 this also makes the remainder equal dividend[3:0].
    logic partial_msb_unused;
    assign partial_msb_unused = partial[4];

    assign partial_sh   = {partial[3:0], dvd[7]};
    assign ge           = (partial_sh >= {1'b0, dvs});
    assign partial_step = ge ? (partial_sh - {1'b0, dvs}) : partial_sh;
    assign dvd_step     = {dvd[6:0], ge};

    always_comb begin
        state_nxt     = state;
        dvd_nxt       = dvd;
        dvs_nxt       = dvs;
        partial_nxt   = partial;
        cnt_nxt       = cnt;
        quotient_nxt  = quotient_q;
        remainder_nxt = remainder_q;
        busy_nxt      = busy_q;
        op_ready_nxt  = op_ready_q;
        dbz_nxt       = dbz_q;

        case (state)
            IDLE, DONE: begin
                if (bus.load) begin
                    state_nxt    = BUSY;
                    dvd_nxt      = bus.dividend;
                    dvs_nxt      = bus.divisor;
                    partial_nxt  = 5'd0;
                    cnt_nxt      = 3'd0;
                    busy_nxt     = 1'b1;
                    op_ready_nxt = 1'b0;
                    dbz_nxt      = 1'b0;
                end
            end

            BUSY: begin
`ifdef DIV_BY_ZERO_CHECK_EN
                if (dvs == 4'd0) begin
                    // dvd is still unshifted on the first BUSY edge.
                    state_nxt     = DONE;
                    quotient_nxt  = 8'hFF;
                    remainder_nxt = dvd[3:0];
                    busy_nxt      = 1'b0;
                    op_ready_nxt  = 1'b1;
                    dbz_nxt       = 1'b1;
                end else
`endif
                begin
                    partial_nxt = partial_step;
                    dvd_nxt     = dvd_step;
                    cnt_nxt     = cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state_nxt     = DONE;
                        quotient_nxt  = dvd_step;
                        remainder_nxt = partial_step[3:0];
                        busy_nxt      = 1'b0;
                        op_ready_nxt  = 1'b1;
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dvd         <= 8'h00;
            dvs         <= 4'h0;
            partial     <= 5'd0;
            cnt         <= 3'd0;
            quotient_q  <= 8'h00;
            remainder_q <= 4'h0;
            busy_q      <= 1'b0;
            op_ready_q  <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state       <= state_nxt;
            dvd         <= dvd_nxt;
            dvs         <= dvs_nxt;
            partial     <= partial_nxt;
            cnt         <= cnt_nxt;
            quotient_q  <= quotient_nxt;
            remainder_q <= remainder_nxt;
            busy_q      <= busy_nxt;
            op_ready_q  <= op_ready_nxt;
            dbz_q       <= dbz_nxt;
        end
    end

    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.busy        = busy_q;
    assign bus.op_ready    = op_ready_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider.sv
// Directed bench for divider: reset, worked examples, ignored loads, reset abort,
// divide-by-zero (both builds) and an exhaustive back-to-back sweep.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_divider;
    logic clk = 1'b0;
    logic rst;
    int   vecs  = 0;
    int   fails = 0;

    divider_if bus ();

    divider dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply a one-cycle load pulse (edge N) then run to edge N+8 and check.
    task automatic run_div(input string tag, input logic [7:0] dd, input logic [3:0] ds,
                           input logic [7:0] eq, input logic [3:0] er);
        bus.load = 1'b1; bus.dividend = dd; bus.divisor = ds;
        tick();
        bus.load = 1'b0;
        repeat (8) tick();
        chk({tag, "_q"}, 32'(bus.quotient), 32'(eq));
        chk({tag, "_r"}, 32'(bus.remainder), 32'(er));
        chk({tag, "_rdy"}, 32'(bus.op_ready), 32'd1);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.load = 1'b0; bus.dividend = 8'h00; bus.divisor = 4'h0;
        #1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_q", 32'(bus.quotient), 32'h00);
        chk("rst_r", 32'(bus.remainder), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_rdy", 32'(bus.op_ready), 32'd0);
        chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);

        // 143 / 11 with mid-run visibility checks
        bus.load = 1'b1; bus.dividend = 8'd143; bus.divisor = 4'd11;
        tick();
        bus.load = 1'b0;
        chk("b1_busy_n", 32'(bus.busy), 32'd1);
        chk("b1_rdy_n", 32'(bus.op_ready), 32'd0);
        repeat (7) tick();
        chk("b1_busy_n7", 32'(bus.busy), 32'd1);
        chk("b1_q_hold", 32'(bus.quotient), 32'h00);
        tick();
        chk("b1_q", 32'(bus.quotient), 32'd13);
        chk("b1_r", 32'(bus.remainder), 32'd0);
        chk("b1_rdy", 32'(bus.op_ready), 32'd1);
        chk("b1_busy", 32'(bus.busy), 32'd0);

        run_div("max", 8'd255, 4'd15, 8'd17, 4'd0);

        // 200 / 7 with an ignored load at N+3
        bus.load = 1'b1; bus.dividend = 8'd200; bus.divisor = 4'd7;
        tick();
        bus.load = 1'b0;
        tick(); tick();
        bus.load = 1'b1; bus.dividend = 8'd9; bus.divisor = 4'd3;
        tick();
        bus.load = 1'b0;
        chk("ign_q_hold", 32'(bus.quotient), 32'd17);
        repeat (5) tick();
        chk("ign_q", 32'(bus.quotient), 32'd28);
        chk("ign_r", 32'(bus.remainder), 32'd4);
        chk("ign_rdy", 32'(bus.op_ready), 32'd1);

        // dividend < divisor, op_ready held until the next load
        run_div("small", 8'd5, 4'd9, 8'd0, 4'd5);
        repeat (3) tick();
        chk("small_rdy_hold", 32'(bus.op_ready), 32'd1);
        bus.load = 1'b1; bus.dividend = 8'd10; bus.divisor = 4'd2;
        tick();
        bus.load = 1'b0;
        chk("reload_rdy_clr", 32'(bus.op_ready), 32'd0);
        chk("reload_r_hold", 32'(bus.remainder), 32'd5);
        repeat (8) tick();
        chk("reload_q", 32'(bus.quotient), 32'd5);
        chk("reload_r", 32'(bus.remainder), 32'd0);

        // reset at N+4 of 100 / 3
        bus.load = 1'b1; bus.dividend = 8'd100; bus.divisor = 4'd3;
        tick();
        bus.load = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("abort_q", 32'(bus.quotient), 32'h00);
        chk("abort_r", 32'(bus.remainder), 32'h0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_rdy", 32'(bus.op_ready), 32'd0);
        // rst and load together: load must lose
        bus.load = 1'b1; bus.dividend = 8'd50; bus.divisor = 4'd5;
        tick();
        chk("rstld_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0; bus.load = 1'b0;
        repeat (9) tick();
        chk("rstld_idle_busy", 32'(bus.busy), 32'd0);
        chk("rstld_idle_rdy", 32'(bus.op_ready), 32'd0);
        chk("rstld_idle_q", 32'(bus.quotient), 32'h00);

        // divide by zero
        bus.load = 1'b1; bus.dividend = 8'hA7; bus.divisor = 4'h0;
        tick();
        bus.load = 1'b0;
        tick();
`ifdef DIV_BY_ZERO_CHECK_EN
        chk("dbz_flag", 32'(bus.div_by_zero), 32'd1);
        chk("dbz_rdy", 32'(bus.op_ready), 32'd1);
        chk("dbz_busy", 32'(bus.busy), 32'd0);
`else
        chk("dbz_busy_n1", 32'(bus.busy), 32'd1);
        repeat (7) tick();
        chk("dbz_rdy", 32'(bus.op_ready), 32'd1);
        chk("dbz_flag", 32'(bus.div_by_zero), 32'd0);
`endif
        chk("dbz_q", 32'(bus.quotient), 32'hFF);
        chk("dbz_r", 32'(bus.remainder), 32'h7);

        // exhaustive sweep with load held high: a new operation starts on
        // the edge after each completion, operands changed only after checking
        bus.load = 1'b1;
        for (int dd = 0; dd < 256; dd++) begin
            for (int ds = 1; ds < 16; ds++) begin
                logic [7:0] eq;
                logic [3:0] er;
                eq = 8'(dd / ds);
                er = 4'(dd % ds);
                bus.dividend = 8'(dd);
                bus.divisor  = 4'(ds);
                tick();
                repeat (8) tick();
                vecs++;
                assert (bus.quotient === eq && bus.remainder === er && bus.op_ready === 1'b1)
                else begin
                    fails++;
                    $error("FAIL sweep %0d/%0d: observed q=%0d r=%0d rdy=%0b expected q=%0d r=%0d rdy=1",
                           dd, ds, bus.quotient, bus.remainder, bus.op_ready, eq, er);
                end
            end
        end
        bus.load = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
